// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared encodings and memory-map defaults for the fetch stage.
package pc_fetch_pkg;
  typedef enum logic [1:0] {NPC_SEQ = 2'd0, NPC_BR = 2'd1, NPC_J = 2'd2, NPC_JR = 2'd3} npc_op_e;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_HALT = 2'd1, ST_FAULT = 2'd2} state_e;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEFAULT = 32'h0000_3000;
  localparam int IM_DEPTH_DEFAULT = 4096;
endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: control inputs and fetch/status outputs of the fetch stage.
interface pc_fetch_if;
  logic        en;
  logic        halt;
  logic [1:0]  npc_op;
  logic        cmp_true;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired_cnt;
  logic [1:0]  state;
  logic        fault;
  logic [31:0] fault_pc;
  modport master (
    input  en, halt, npc_op, cmp_true, imm16, instr_index, jr_target,
    output pc, pc_plus4, retired_cnt, state, fault, fault_pc
  );
  modport slave (
    output en, halt, npc_op, cmp_true, imm16, instr_index, jr_target,
    input  pc, pc_plus4, retired_cnt, state, fault, fault_pc
  );
endinterface

// File: rtl/pc_fetch_npc_calc.sv
// pc_fetch_npc_calc: combinational next-PC target and instruction-window legality.
module pc_fetch_npc_calc
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] IM_BASE = IM_BASE_DEFAULT,
  parameter int IM_DEPTH = IM_DEPTH_DEFAULT
) (
  input  logic [31:0] pc_i,
  input  npc_op_e     npc_op_i,
  input  logic        cmp_true_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] instr_index_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] target_o,
  output logic        legal_o
);
  // 33-bit bounds keep the top-of-window compare from overflowing
  localparam logic [32:0] LO = {1'b0, IM_BASE};
  localparam logic [32:0] HI = LO + (33'(IM_DEPTH) << 2) - 33'd4;
  logic [31:0] br_off;
  assign pc_plus4_o = pc_i + 32'd4;
  assign br_off = {{14{imm16_i[15]}}, imm16_i, 2'b00};
  assign target_o = npc_op_i == NPC_JR ? jr_target_i :
                    npc_op_i == NPC_J ? {pc_plus4_o[31:28], instr_index_i, 2'b00} :
                    npc_op_i == NPC_BR && cmp_true_i ? pc_plus4_o + br_off : pc_plus4_o;
  assign legal_o = target_o[1:0] == 2'b00 && {1'b0, target_o} >= LO && {1'b0, target_o} <= HI;
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter, retire counter and RUN/HALT/FAULT control.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter logic [31:0] IM_BASE = IM_BASE_DEFAULT,
  parameter int IM_DEPTH = IM_DEPTH_DEFAULT
) (
  input logic clk,
  input logic reset,
  pc_fetch_if.master bus
);
  state_e      state_q;
  logic [31:0] pc_q, pc_d, cnt_q, fault_pc_q;
  logic        fault_q, legal;
  pc_fetch_npc_calc #(.IM_BASE(IM_BASE), .IM_DEPTH(IM_DEPTH)) u_npc (
    .pc_i(pc_q),
    .npc_op_i(npc_op_e'(bus.npc_op)),
    .cmp_true_i(bus.cmp_true),
    .imm16_i(bus.imm16),
    .instr_index_i(bus.instr_index),
    .jr_target_i(bus.jr_target),
    .pc_plus4_o(bus.pc_plus4),
    .target_o(pc_d),
    .legal_o(legal)
  );
  // HALT and FAULT are absorbing: only reset leaves them
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q <= PC_RESET;
      cnt_q <= '0;
      fault_q <= 1'b0;
      fault_pc_q <= '0;
    end else if (state_q == ST_RUN) begin
      if (bus.halt) begin
        state_q <= ST_HALT;
      end else if (bus.en && !legal) begin
        state_q <= ST_FAULT;
        fault_q <= 1'b1;
        fault_pc_q <= pc_q;
      end else if (bus.en) begin
        pc_q <= pc_d;
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end
  assign bus.pc = pc_q;
  assign bus.retired_cnt = cnt_q;
  assign bus.state = state_q;
  assign bus.fault = fault_q;
  assign bus.fault_pc = fault_pc_q;
endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Fetch-side initiator for the instruction memory: holds the program counter and drives the fetch address every cycle.
- Computes the next PC from the sequential, branch, jump and jump-register paths.
- Range-checks and alignment-checks every PC update against the instruction memory window; freezes on a fault or on halt.
- Sits between the controller/comparator and the instruction memory address port in the single-cycle datapath.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, byte address of instruction memory word 0.
- IM_DEPTH, 4096, instruction memory depth in 32-bit words.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  advance enable; low = stall, PC holds.
- halt  input  1  request to stop fetching.
- npc_op  input  2  next-PC select: 0 SEQ, 1 BR, 2 J, 3 JR.
- cmp_true  input  1  branch condition result, used only when npc_op=BR.
- imm16  input  16  branch offset in words, signed.
- instr_index  input  26  jump target index (J/JAL).
- jr_target  input  32  register value for JR.
- pc  output  32  current fetch address, driven to the instruction memory.
- pc_plus4  output  32  pc+4, combinational, used as the link value for JAL.
- retired_cnt  output  32  number of PC advances since reset.
- state  output  2  0 RUN, 1 HALT, 2 FAULT.
- fault  output  1  high while state=FAULT.
- fault_pc  output  32  PC value at which the fault occurred.

Behaviour:
- Reset values: pc=PC_RESET, retired_cnt=0, state=RUN, fault=0, fault_pc=0. pc_plus4 is PC_RESET+4 immediately after reset.
- Target computation, combinational and all 32-bit with wrap-around modulo 2^32:
  - SEQ: pc+4.
  - BR: pc+4+(sext(imm16)<<2) when cmp_true=1; otherwise pc+4.
  - J: {pc_plus4[31:28], instr_index, 2'b00}.
  - JR: jr_target.
- Legal target: target[1:0]==0 and IM_BASE <= target <= IM_BASE+4*IM_DEPTH-4. Compare in 33 bits so the upper bound cannot overflow.
- Per-edge priority, in state RUN: reset > halt > (en=0) > illegal target > normal advance.
  - halt=1: go to HALT; pc holds; no count.
  - en=0: hold everything.
  - en=1 and target illegal: go to FAULT; pc holds; fault_pc<=pc; retired_cnt unchanged.
  - en=1 and target legal: pc<=target; retired_cnt<=retired_cnt+1 (wraps at 2^32).
- HALT and FAULT are absorbing. Only reset leaves them. In both states en, halt and npc_op are ignored, and pc, retired_cnt and fault_pc hold.
- Latency: a new pc is visible one edge after the npc_op/en cycle. There is no pipeline or delay slot.
- Reset asserted mid-operation, in any state, restores all reset values on that edge. A reset edge does not increment the count.
- A legal branch to self (imm16=16'hFFFF) is a normal advance: pc is unchanged and retired_cnt increments.
- Undefined inputs while in HALT or FAULT do not affect any output.

Decomposition:
- Shared package (pc_fetch_pkg) holds:
  - npc_op encodings SEQ/BR/J/JR.
  - state encodings RUN/HALT/FAULT.
  - the IM_BASE and PC_RESET defaults, shared with the instruction and data memory blocks.
- One natural sub-module: npc_calc. It is purely combinational and produces the target plus a legal flag from pc, npc_op, cmp_true, imm16, instr_index and jr_target. The pc_fetch top holds the PC register, counter and FSM.

Test Plan:
- Reset, then 3 cycles en=1 SEQ -> pc goes 3000, 3004, 3008, 300C; retired_cnt=3; state=RUN.
- At pc=3008: BR with imm16=FFFE and cmp_true=1 -> pc=3004. The same step with cmp_true=0 -> pc=300C.
- J with instr_index=26'h0000C40 from pc=3000 -> pc=3100. Then JR with jr_target=3200 -> pc=3200. en=0 for 2 cycles -> pc and count hold.
- JR to 0000_3002 (misaligned) -> state=FAULT, fault=1, fault_pc=old pc, pc unchanged. Further SEQ with en=1 -> no change. A reset pulse -> pc=3000, fault=0, count=0.
- JR to 0000_7000 (one past the top, IM_DEPTH=4096) -> FAULT. JR to 0000_6FFC -> legal advance.
- halt=1 together with an illegal JR -> state=HALT, fault=0. Later en/JR inputs are ignored. A reset asserted while in HALT returns to RUN at 3000.
